// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared states, opcodes and decoded-op flags for the control sequencer
package control_sequencer_pkg;

   localparam int OPW_DEF = 4;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC1 = 2'd1,
      S_EXEC2 = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam int OP_LDA = 0;
   localparam int OP_STA = 1;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_JMP = 4;
   localparam int OP_JMI = 5;
   localparam int OP_JEQ = 6;
   localparam int OP_STP = 7;
   localparam int OP_LDI = 8;

   typedef struct packed {
      logic lda;
      logic sta;
      logic add;
      logic sub;
      logic jmp;
      logic jmi;
      logic jeq;
      logic stp;
      logic ldi;
      logic illegal;
   } op_t;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// opcode_decoder: maps the opcode field to one-hot op flags plus an illegal flag
module opcode_decoder
   import control_sequencer_pkg::*;
#(
   parameter int OPW = OPW_DEF
) (
   input  logic [OPW-1:0] ir,
   output op_t            op
);

   // one flag per known opcode; anything unmatched is illegal
   always_comb begin
      op         = '0;
      op.lda     = ir == OPW'(OP_LDA);
      op.sta     = ir == OPW'(OP_STA);
      op.add     = ir == OPW'(OP_ADD);
      op.sub     = ir == OPW'(OP_SUB);
      op.jmp     = ir == OPW'(OP_JMP);
      op.jmi     = ir == OPW'(OP_JMI);
      op.jeq     = ir == OPW'(OP_JEQ);
      op.stp     = ir == OPW'(OP_STP);
      op.ldi     = ir == OPW'(OP_LDI);
      op.illegal = !(op.lda | op.sta | op.add | op.sub | op.jmp | op.jmi | op.jeq | op.stp | op.ldi);
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute state machine driving the datapath controls
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int OPW     = OPW_DEF,
   parameter bit WAIT_EN = 1'b1
) (
   input  logic           CLK,
   input  logic           RESET_N,
   input  logic [OPW-1:0] IR,
   input  logic           EQ,
   input  logic           MI,
   input  logic           MEM_RDY,
   input  logic           GO,
   output logic           FETCH,
   output logic           EXEC1,
   output logic           EXEC2,
   output logic           HALTED,
   output logic           IR_LOAD,
   output logic           Wren,
   output logic           MUX1,
   output logic           MUX3,
   output logic           MUX3_useAllBits,
   output logic           PC_sload,
   output logic           PC_cnt_en,
   output logic           ACC_EN,
   output logic           ACC_LOAD,
   output logic           ADDSUB,
   output logic           ILLEGAL
);

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   op_t    op;
   logic   stall;
   logic   alu_ex2;

   opcode_decoder #(.OPW(OPW)) u_dec (
      .ir (IR),
      .op (op)
   );

   // HALT is not a memory-cycle state, so it never stalls
   assign stall = WAIT_EN && !MEM_RDY && state_q != S_HALT;

   assign FETCH  = state_q == S_FETCH;
   assign EXEC1  = state_q == S_EXEC1;
   assign EXEC2  = state_q == S_EXEC2;
   assign HALTED = state_q == S_HALT;

   assign alu_ex2 = EXEC2 & (op.lda | op.add | op.sub);

   // datapath controls; strobes that change architectural state are suppressed while stalled
   always_comb begin
      IR_LOAD         = FETCH & !stall;
      MUX1            = EXEC1 & (op.lda | op.sta | op.add | op.sub);
      Wren            = EXEC1 & op.sta & !stall;
      MUX3            = EXEC2 & op.lda | EXEC1 & op.ldi;
      MUX3_useAllBits = EXEC2 & op.lda;
      ACC_LOAD        = alu_ex2 | EXEC1 & op.ldi;
      ACC_EN          = ACC_LOAD & !stall;
      ADDSUB          = EXEC2 & op.add;
      PC_sload        = EXEC1 & (op.jmp | op.jmi & MI | op.jeq & EQ) & !stall;
      PC_cnt_en       = (alu_ex2 | EXEC1 & (op.sta | op.ldi | op.jmi & !MI | op.jeq & !EQ | op.illegal)) & !stall;
   end

   // next state and sticky illegal-opcode flag
   always_comb begin
      state_d   = stall             ? state_q :
                  state_q == S_FETCH ? S_EXEC1 :
                  state_q == S_EXEC1 ? ((op.lda | op.add | op.sub) ? S_EXEC2 : op.stp ? S_HALT : S_FETCH) :
                  state_q == S_EXEC2 ? S_FETCH :
                  GO                 ? S_FETCH : S_HALT;
      illegal_d = illegal_q | (EXEC1 & op.illegal & !stall);
   end

   assign ILLEGAL = illegal_q;

   // state register with asynchronous reset to FETCH
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer (OPW=4 and OPW=6 builds)
module tb_control_sequencer;

   typedef struct {
      string       tag;
      bit          sel;
      logic [14:0] exp;
   } sb_t;

   localparam logic [14:0] ST_F  = 15'h4000;
   localparam logic [14:0] ST_E1 = 15'h2000;
   localparam logic [14:0] ST_E2 = 15'h1000;
   localparam logic [14:0] ST_H  = 15'h0800;
   localparam logic [14:0] C_IRL = 15'h0400;
   localparam logic [14:0] C_WR  = 15'h0200;
   localparam logic [14:0] C_M1  = 15'h0100;
   localparam logic [14:0] C_M3  = 15'h0080;
   localparam logic [14:0] C_M3A = 15'h0040;
   localparam logic [14:0] C_PS  = 15'h0020;
   localparam logic [14:0] C_PC  = 15'h0010;
   localparam logic [14:0] C_AE  = 15'h0008;
   localparam logic [14:0] C_AL  = 15'h0004;
   localparam logic [14:0] C_AS  = 15'h0002;
   localparam logic [14:0] C_IL  = 15'h0001;
   localparam logic [14:0] C_ALU = C_AE | C_AL | C_PC;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] ir4;
   logic [5:0] ir6;
   logic       eq, mi, rdy, go;
   logic [14:0] v4, v6;
   logic f4, e14, e24, h4, irl4, wr4, m14, m34, m3a4, ps4, pc4, ae4, al4, as4, il4;
   logic f6, e16, e26, h6, irl6, wr6, m16, m36, m3a6, ps6, pc6, ae6, al6, as6, il6;

   sb_t sb[$];
   sb_t mon_e;
   int  n_chk = 0;
   int  n_err = 0;

   always #5 clk = ~clk;

   control_sequencer #(.OPW(4), .WAIT_EN(1'b1)) u_dut4 (
      .CLK (clk), .RESET_N (rst_n), .IR (ir4), .EQ (eq), .MI (mi), .MEM_RDY (rdy), .GO (go),
      .FETCH (f4), .EXEC1 (e14), .EXEC2 (e24), .HALTED (h4),
      .IR_LOAD (irl4), .Wren (wr4), .MUX1 (m14), .MUX3 (m34), .MUX3_useAllBits (m3a4),
      .PC_sload (ps4), .PC_cnt_en (pc4), .ACC_EN (ae4), .ACC_LOAD (al4), .ADDSUB (as4),
      .ILLEGAL (il4)
   );

   control_sequencer #(.OPW(6), .WAIT_EN(1'b1)) u_dut6 (
      .CLK (clk), .RESET_N (rst_n), .IR (ir6), .EQ (eq), .MI (mi), .MEM_RDY (rdy), .GO (go),
      .FETCH (f6), .EXEC1 (e16), .EXEC2 (e26), .HALTED (h6),
      .IR_LOAD (irl6), .Wren (wr6), .MUX1 (m16), .MUX3 (m36), .MUX3_useAllBits (m3a6),
      .PC_sload (ps6), .PC_cnt_en (pc6), .ACC_EN (ae6), .ACC_LOAD (al6), .ADDSUB (as6),
      .ILLEGAL (il6)
   );

   assign v4 = {f4, e14, e24, h4, irl4, wr4, m14, m34, m3a4, ps4, pc4, ae4, al4, as4, il4};
   assign v6 = {f6, e16, e26, h6, irl6, wr6, m16, m36, m3a6, ps6, pc6, ae6, al6, as6, il6};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive one cycle of inputs and queue the outputs expected in that cycle
   task automatic cyc(input string tag, input bit sel, input logic [7:0] ir,
                      input logic e, input logic m, input logic r, input logic g,
                      input logic [14:0] exp);
      sb_t s;
      ir4 = ir[3:0];
      ir6 = ir[5:0];
      eq  = e;
      mi  = m;
      rdy = r;
      go  = g;
      s.tag = tag;
      s.sel = sel;
      s.exp = exp;
      sb.push_back(s);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check(mon_e.tag, {17'd0, mon_e.sel ? v6 : v4}, {17'd0, mon_e.exp});
      end
   end

   initial begin
      rst_n = 1'b0;
      ir4 = '0; ir6 = '0; eq = 0; mi = 0; rdy = 1; go = 0;
      @(posedge clk);
      #1;
      cyc("rst_hold",     0, 8'd0, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("rst_hold_st",  0, 8'd1, 0, 0, 0, 0, ST_F);
      rst_n = 1'b1;
      cyc("lda_f",        0, 8'd0, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("lda_e1",       0, 8'd0, 0, 0, 1, 0, ST_E1 | C_M1);
      cyc("lda_e2",       0, 8'd0, 0, 0, 1, 0, ST_E2 | C_ALU | C_M3 | C_M3A);
      cyc("jeq1_f",       0, 8'd6, 1, 0, 1, 0, ST_F | C_IRL);
      cyc("jeq1_e1",      0, 8'd6, 1, 0, 1, 0, ST_E1 | C_PS);
      cyc("jeq0_f",       0, 8'd6, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("jeq0_e1",      0, 8'd6, 0, 0, 1, 0, ST_E1 | C_PC);
      cyc("jmi1_f",       0, 8'd5, 0, 1, 1, 0, ST_F | C_IRL);
      cyc("jmi1_e1",      0, 8'd5, 0, 1, 1, 0, ST_E1 | C_PS);
      cyc("jmi0_f",       0, 8'd5, 1, 0, 1, 0, ST_F | C_IRL);
      cyc("jmi0_e1",      0, 8'd5, 1, 0, 1, 0, ST_E1 | C_PC);
      cyc("ldi_f",        0, 8'd8, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("ldi_e1",       0, 8'd8, 0, 0, 1, 0, ST_E1 | C_M3 | C_AE | C_AL | C_PC);
      cyc("sub_f",        0, 8'd3, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("sub_e1",       0, 8'd3, 0, 0, 1, 0, ST_E1 | C_M1);
      cyc("sub_e2",       0, 8'd3, 0, 0, 1, 0, ST_E2 | C_ALU);
      cyc("add_f",        0, 8'd2, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("add_e1",       0, 8'd2, 0, 0, 1, 0, ST_E1 | C_M1);
      cyc("add_e2",       0, 8'd2, 0, 0, 1, 0, ST_E2 | C_ALU | C_AS);
      cyc("f_stall",      0, 8'd1, 0, 0, 0, 0, ST_F);
      cyc("sta_f",        0, 8'd1, 0, 0, 1, 0, ST_F | C_IRL);
      for (int i = 0; i < 3; i++)
         cyc("sta_stall",  0, 8'd1, 0, 0, 0, 0, ST_E1 | C_M1);
      cyc("sta_e1",       0, 8'd1, 0, 0, 1, 0, ST_E1 | C_M1 | C_WR | C_PC);
      cyc("sta_done",     0, 8'd1, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("stp_e1",       0, 8'd7, 0, 0, 1, 0, ST_E1);
      for (int i = 0; i < 10; i++)
         cyc("halt",       0, 8'(i + 1), i[0], i[1], i[2], 0, ST_H);
      cyc("halt_go",      0, 8'd7, 0, 0, 1, 1, ST_H);
      cyc("go_f",         0, 8'd4, 0, 0, 1, 1, ST_F | C_IRL);
      cyc("jmp_e1",       0, 8'd4, 0, 0, 1, 1, ST_E1 | C_PS);
      cyc("ill_f",        0, 8'h0F, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("ill_e1",       0, 8'h0F, 0, 0, 1, 0, ST_E1 | C_PC);
      cyc("ill_lda_f",    0, 8'd0, 0, 0, 1, 0, ST_F | C_IRL | C_IL);
      cyc("ill_lda_e1",   0, 8'd0, 0, 0, 1, 0, ST_E1 | C_M1 | C_IL);
      cyc("ill_lda_e2",   0, 8'd0, 0, 0, 1, 0, ST_E2 | C_ALU | C_M3 | C_M3A | C_IL);
      cyc("ill_add_f",    0, 8'd2, 0, 0, 1, 0, ST_F | C_IRL | C_IL);
      cyc("ill_add_e1",   0, 8'd2, 0, 0, 1, 0, ST_E1 | C_M1 | C_IL);
      #1;
      check("add_e2_pre", {17'd0, v4}, {17'd0, ST_E2 | C_ALU | C_AS | C_IL});
      rst_n = 1'b0;
      #1;
      check("rst_async",  {17'd0, v4}, {17'd0, ST_F | C_IRL});
      @(posedge clk);
      #1;
      cyc("rst_mid",      0, 8'd2, 0, 0, 1, 0, ST_F | C_IRL);
      rst_n = 1'b1;
      cyc("o6_f",         1, 8'd0, 0, 0, 1, 0, ST_F | C_IRL);
      cyc("o6_e1",        1, 8'd0, 0, 0, 1, 0, ST_E1 | C_M1);
      cyc("o6_e2",        1, 8'd0, 0, 0, 1, 0, ST_E2 | C_ALU | C_M3 | C_M3A);
      cyc("o6_f2",        1, 8'd0, 0, 0, 1, 0, ST_F | C_IRL);
      check("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 4, opcode width; legal range 4..8.
REQ-002 Parameter WAIT_EN, default 1; 1 enables the MEM_RDY stall handshake, 0 ties it off internally.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 IR  input  OPW  opcode field of the instruction register.
REQ-006 EQ, MI  input  1 each  accumulator zero flag and negative flag.
REQ-007 MEM_RDY  input  1  memory ready; low stalls the sequencer when WAIT_EN=1.
REQ-008 GO  input  1  single-cycle pulse that restarts the sequencer from HALT.
REQ-009 FETCH, EXEC1, EXEC2, HALTED  output  1 each  one-hot state indicators.
REQ-010 IR_LOAD, Wren, MUX1, MUX3, MUX3_useAllBits, PC_sload, PC_cnt_en, ACC_EN, ACC_LOAD, ADDSUB  output  1 each  datapath controls.
REQ-011 ILLEGAL  output  1  sticky flag, set on any undecoded opcode.

Function
REQ-012 States: S_FETCH, S_EXEC1, S_EXEC2, S_HALT; registered; exactly one state indicator is high at any time.
REQ-013 The sequencer moves S_FETCH -> S_EXEC1 unconditionally, unstalled.
REQ-014 In S_EXEC1:
 - LDA, ADD and SUB go to S_EXEC2.
 - STP goes to S_HALT.
 - All other opcodes go to S_FETCH.
REQ-015 The sequencer moves S_EXEC2 -> S_FETCH.
REQ-016 S_HALT holds until GO=1, then goes to S_FETCH; GO in any other state is ignored.
REQ-017 Stall: when WAIT_EN=1 and MEM_RDY=0 in S_FETCH, S_EXEC1 or S_EXEC2, the following hold.
 - State is held.
 - Wren, IR_LOAD, PC_sload, PC_cnt_en and ACC_EN are forced to 0.
 - Mux selects keep their decoded values.
REQ-018 Opcodes (zero-extended to OPW): LDA=0, STA=1, ADD=2, SUB=3, JMP=4, JMI=5, JEQ=6, STP=7, LDI=8.
REQ-019 Outputs are combinational from state, IR, EQ, MI and stall; each listed condition is ORed, and every output is 0 otherwise.
REQ-020 IR_LOAD = FETCH.
REQ-021 MUX1 = EXEC1 & (LDA|STA|ADD|SUB).
REQ-022 Wren = EXEC1 & STA.
REQ-023 MUX3 = EXEC2 & LDA | EXEC1 & LDI.
REQ-024 MUX3_useAllBits = EXEC2 & LDA.
REQ-025 ACC_EN = ACC_LOAD = EXEC2 & (LDA|ADD|SUB) | EXEC1 & LDI.
REQ-026 ADDSUB = EXEC2 & ADD.
REQ-027 PC_sload = EXEC1 & (JMP | JMI&MI | JEQ&EQ).
REQ-028 PC_cnt_en = EXEC2 & (LDA|ADD|SUB) | EXEC1 & (STA | LDI | JMI&!MI | JEQ&!EQ | illegal).
REQ-029 PC_sload and PC_cnt_en are never high in the same cycle.
REQ-030 Illegal opcode: in EXEC1 it behaves as a NOP (PC increments, next state S_FETCH) and sets ILLEGAL on the next edge; only reset clears ILLEGAL.
REQ-031 STP in EXEC1 asserts no datapath control; the PC is not incremented.
REQ-032 No output depends on IR while in S_HALT; all datapath controls are 0 there.

Reset
REQ-033 RESET_N low asynchronously forces S_FETCH and clears ILLEGAL, including mid-instruction or mid-stall.
REQ-034 While reset is held, Wren=0, PC_sload=0, PC_cnt_en=0 and ACC_EN=0; FETCH=1, and EXEC1, EXEC2 and HALTED are 0.
REQ-035 The first active edge after release executes S_FETCH with IR_LOAD=1.

Structure
REQ-036 A shared package holds:
 - the state enum (S_FETCH, S_EXEC1, S_EXEC2, S_HALT);
 - the opcode constants;
 - the OPW default.
REQ-037 One sub-module, opcode_decoder, maps IR to one-hot op flags plus an illegal flag; the sequencer owns the state register and output equations.

Verification
REQ-038 Reset release, IR=0 (LDA), MEM_RDY=1 -> FETCH, EXEC1 (MUX1=1), EXEC2 (MUX3=ACC_EN=PC_cnt_en=MUX3_useAllBits=1), FETCH.
REQ-039 IR=6 (JEQ) with EQ=1 -> EXEC1 PC_sload=1, PC_cnt_en=0; repeat with EQ=0 -> PC_sload=0, PC_cnt_en=1.
REQ-040 IR=7 (STP) -> HALTED=1 and all controls 0 for 10 cycles; GO pulse -> FETCH on the next edge.
REQ-041 IR=1 (STA), MEM_RDY=0 for 3 cycles in EXEC1 -> state held and Wren=0 for those cycles; Wren=1 for exactly one cycle once MEM_RDY=1.
REQ-042 IR=4'hF -> EXEC1 PC_cnt_en=1, then ILLEGAL=1 sticky through subsequent legal instructions; cleared only by RESET_N.
REQ-043 RESET_N pulled low during EXEC2 of ADD -> immediate S_FETCH, ACC_EN=0 with no clock edge; OPW=6 build repeats REQ-038 with IR=6'h00.
